// File: rtl/core_pkg.sv
// Shared types and constants for the 8-bit core.
// Fetch FSM state encoding, widths and branch selectors.
package core_pkg;

  localparam int CORE_PC_W   = 10;
  localparam int CORE_LUT_AW = 4;

  typedef enum logic [1:0] {
    FS_IDLE   = 2'd0,
    FS_RUN    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  // Branch condition selects, shared with ALU func codes
  localparam logic BR_BNO = 1'b0;
  localparam logic BR_BOF = 1'b1;

endpackage

// File: rtl/branch_lut.sv
// Branch target table: gated write port, async clear,
// combinational read.
module branch_lut #(
  parameter int AW = 4,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int N = 2 ** AW;

  logic [DW-1:0] mem_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// PC sequencing and BNO/BOF branch resolution stage.
// Holds PC, run/halt FSM and the branch target table.
module fetch_unit
  import core_pkg::*;
#(
  parameter int PC_W   = CORE_PC_W,
  parameter int LUT_AW = CORE_LUT_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              branch_en,
  input  logic              branch_sel,
  input  logic              flag,
  input  logic [LUT_AW-1:0] lut_idx,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc,
  output logic              pc_valid,
  output logic              running,
  output logic              done
);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] lut_rdata;
  logic            valid_q;
  logic            run_q;
  logic            done_q;
  logic            taken;
  logic            lut_we_g;

  // Table may only change while no program is executing
  assign lut_we_g = lut_we & (state_q != FS_RUN);

  branch_lut #(
    .AW (LUT_AW),
    .DW (PC_W)
  ) u_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (lut_we_g),
    .waddr_i (lut_waddr),
    .wdata_i (lut_wdata),
    .raddr_i (lut_idx),
    .rdata_o (lut_rdata)
  );

  assign taken = branch_en & (flag == branch_sel);
  assign pc_d  = taken ? lut_rdata : pc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        FS_IDLE, FS_HALTED: begin
          if (start) begin
            state_q <= FS_RUN;
            pc_q    <= start_addr;
            valid_q <= 1'b1;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        FS_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state_q <= FS_HALTED;
              valid_q <= 1'b0;
              run_q   <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        default: begin
          state_q <= FS_IDLE;
          pc_q    <= '0;
          valid_q <= 1'b0;
          run_q   <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc       = pc_q;
  assign pc_valid = valid_q;
  assign running  = run_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios
// plus random stimulus against a behavioural model.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int PW = CORE_PC_W;
  localparam int AW = CORE_LUT_AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] start_addr;
  logic          stall;
  logic          halt_req;
  logic          branch_en;
  logic          branch_sel;
  logic          flag;
  logic [AW-1:0] lut_idx;
  logic          lut_we;
  logic [AW-1:0] lut_waddr;
  logic [PW-1:0] lut_wdata;
  logic [PW-1:0] pc;
  logic          pc_valid;
  logic          running;
  logic          done;

  int errors = 0;
  int checks = 0;

  // model: mode 0 idle, 1 run, 2 halted
  int            m_mode;
  logic [PW-1:0] m_pc;
  logic          m_done;
  logic [PW-1:0] m_lut [2**AW];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .halt_req   (halt_req),
    .branch_en  (branch_en),
    .branch_sel (branch_sel),
    .flag       (flag),
    .lut_idx    (lut_idx),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .running    (running),
    .done       (done)
  );

  function automatic logic [PW+2:0] exp_vec();
    return {m_pc, m_mode == 1, m_mode == 1, m_done};
  endfunction

  function automatic logic [PW+2:0] dut_vec();
    return {pc, pc_valid, running, done};
  endfunction

  task automatic clr_inputs();
    start = 0; start_addr = '0; stall = 0; halt_req = 0;
    branch_en = 0; branch_sel = 0; flag = 0; lut_idx = '0;
    lut_we = 0; lut_waddr = '0; lut_wdata = '0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_done = 0;
    for (int i = 0; i < 2**AW; i++) m_lut[i] = '0;
  endtask

  // Advance model from current inputs, then clock the DUT
  task automatic tick();
    int old_mode;
    old_mode = m_mode;
    if (m_mode == 1) begin
      if (!stall) begin
        if (halt_req) begin
          m_mode = 2; m_done = 1;
        end else if (branch_en && flag == branch_sel) begin
          m_pc = m_lut[lut_idx];
        end else begin
          m_pc = PW'((int'(m_pc) + 1) % (1 << PW));
        end
      end
    end else if (start) begin
      m_mode = 1; m_pc = start_addr; m_done = 0;
    end
    if (old_mode != 1 && lut_we) m_lut[lut_waddr] = lut_wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    checks++;
    if (dut_vec() !== {10'h000, 3'b000}) begin
      errors++;
      $display("FAIL reset: got %h want %h", dut_vec(), {10'h000, 3'b000});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pc !== 10'h000 || pc_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: pc=%h v=%b want 000/0", pc, pc_valid);
      end
    end
  endtask

  task automatic test_seq();
    start = 1; start_addr = 10'h010;
    tick();
    clr_inputs();
    checks++;
    if (pc !== 10'h010 || running !== 1'b1 || pc_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_start: pc=%h run=%b want 010/1", pc, running);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++;
      if (pc !== PW'(16 + i) || running !== 1'b1) begin
        errors++;
        $display("FAIL seq_inc: pc=%h want %h", pc, PW'(16 + i));
      end
    end
    halt_req = 1;
    tick();
    clr_inputs();
    checks++;
    if (dut_vec() !== {10'h013, 3'b001}) begin
      errors++;
      $display("FAIL seq_halt: got %h want %h", dut_vec(), {10'h013, 3'b001});
    end
  endtask

  task automatic restart(input logic [PW-1:0] a);
    if (m_mode == 1) begin
      halt_req = 1; tick(); clr_inputs();
    end
    start = 1; start_addr = a; tick(); clr_inputs();
  endtask

  task automatic branch(input logic [AW-1:0] idx, input logic sel,
                        input logic f);
    branch_en = 1; lut_idx = idx; branch_sel = sel; flag = f;
    tick();
    clr_inputs();
  endtask

  task automatic test_branch();
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h200;
    tick();
    clr_inputs();
    restart(10'h020);
    branch(4'd3, BR_BOF, 1'b1);
    checks++;
    if (pc !== 10'h200) begin
      errors++;
      $display("FAIL bof_taken: pc=%h want 200", pc);
    end
    restart(10'h020);
    branch(4'd3, BR_BOF, 1'b0);
    checks++;
    if (pc !== 10'h021) begin
      errors++;
      $display("FAIL bof_not_taken: pc=%h want 021", pc);
    end
    branch(4'd3, BR_BNO, 1'b0);
    checks++;
    if (pc !== 10'h200) begin
      errors++;
      $display("FAIL bno_taken: pc=%h want 200", pc);
    end
    branch(4'd3, BR_BNO, 1'b1);
    checks++;
    if (pc !== 10'h201) begin
      errors++;
      $display("FAIL bno_not_taken: pc=%h want 201", pc);
    end
  endtask

  task automatic test_stall();
    restart(10'h040);
    for (int i = 0; i < 2; i++) begin
      stall = 1; halt_req = 1; branch_en = 1; flag = 1; branch_sel = 1;
      tick();
      checks++;
      if (pc !== 10'h040 || running !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: pc=%h run=%b done=%b want 040/1/0",
                 pc, running, done);
      end
    end
    clr_inputs();
    halt_req = 1;
    tick();
    clr_inputs();
    checks++;
    if (dut_vec() !== {10'h040, 3'b001}) begin
      errors++;
      $display("FAIL stall_release: got %h want %h", dut_vec(), {10'h040, 3'b001});
    end
  endtask

  task automatic test_wrap();
    restart(10'h3FE);
    tick();
    checks++;
    if (pc !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_max: pc=%h want 3ff", pc);
    end
    tick();
    checks++;
    if (pc !== 10'h000 || running !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero: pc=%h want 000", pc);
    end
    halt_req = 1;
    tick();
    clr_inputs();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_halt: done=%b want 1", done);
    end
    start = 1; start_addr = 10'h005;
    tick();
    clr_inputs();
    checks++;
    if (dut_vec() !== {10'h005, 3'b110}) begin
      errors++;
      $display("FAIL restart: got %h want %h", dut_vec(), {10'h005, 3'b110});
    end
  endtask

  task automatic test_lut_lockout();
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 10'h111;
    tick();
    clr_inputs();
    branch(4'd1, BR_BOF, 1'b1);
    checks++;
    if (pc !== 10'h000) begin
      errors++;
      $display("FAIL lut_run_write: pc=%h want 000", pc);
    end
    halt_req = 1; tick(); clr_inputs();
    lut_we = 1; lut_waddr = 4'd1; lut_wdata = 10'h111;
    tick();
    clr_inputs();
    restart(10'h030);
    branch(4'd1, BR_BOF, 1'b1);
    checks++;
    if (pc !== 10'h111) begin
      errors++;
      $display("FAIL lut_halt_write: pc=%h want 111", pc);
    end
  endtask

  task automatic test_reset_midrun();
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== {10'h000, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", dut_vec(), {10'h000, 3'b000});
    end
    @(posedge clk); #1;
    rst_n = 1;
    clr_inputs();
    restart(10'h050);
    branch(4'd3, BR_BOF, 1'b1);
    checks++;
    if (pc !== 10'h000) begin
      errors++;
      $display("FAIL lut_cleared: pc=%h want 000", pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      start      = ($urandom_range(0, 3) == 0);
      start_addr = PW'($urandom);
      stall      = ($urandom_range(0, 4) == 0);
      halt_req   = ($urandom_range(0, 11) == 0);
      branch_en  = ($urandom_range(0, 2) == 0);
      branch_sel = 1'($urandom);
      flag       = 1'($urandom);
      lut_idx    = AW'($urandom);
      lut_we     = ($urandom_range(0, 1) == 0);
      lut_waddr  = AW'($urandom);
      lut_wdata  = PW'($urandom);
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", n, dut_vec(), exp_vec());
      end
    end
    clr_inputs();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_stall();
    test_wrap();
    test_lut_lockout();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and branch-resolution stage that sits directly upstream of the ALU in the 8-bit core. It holds the PC that addresses instruction ROM and sequences the program through run and halt. It resolves BNO/BOF branches using the ALU's registered overflow flag, and takes absolute targets from a small branch lookup table. The table is loaded while the core is idle.

Parameters:
PC_W, 10, PC / instruction ROM address width
LUT_AW, 4, branch LUT index width (2^LUT_AW entries)

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  begin execution at start_addr (honoured in IDLE/HALTED only)
start_addr  in  PC_W  first instruction address
stall  in  1  hold PC and state this cycle
halt_req  in  1  decoded HALT instruction at current PC
branch_en  in  1  decoded branch instruction at current PC
branch_sel  in  1  0 = branch if flag==0 (BNO), 1 = branch if flag==1 (BOF)
flag  in  1  ALU registered overflow flag
lut_idx  in  LUT_AW  branch LUT entry for current branch
lut_we  in  1  LUT write enable
lut_waddr  in  LUT_AW  LUT write index
lut_wdata  in  PC_W  LUT write data (absolute target)
pc  out  PC_W  current instruction address
pc_valid  out  1  pc addresses a live instruction
running  out  1  state == RUN
done  out  1  program halted, sticky until next start

Behaviour:
- Reset (async assert): state=IDLE, pc=0, pc_valid=0, running=0, done=0, all LUT entries=0. Release is synchronous to the next edge.
- States: IDLE, RUN, HALTED. 2-bit encoding; any unused encoding goes to IDLE.
- IDLE: start=1 -> next edge: pc=start_addr, state=RUN, pc_valid=1. Otherwise hold.
- RUN, per edge, in priority order:
  - stall=1: hold pc and state; halt_req/branch_en ignored this cycle.
  - halt_req=1: state=HALTED, done=1, pc_valid=0, pc holds the HALT address.
  - taken = branch_en & (flag == branch_sel); taken -> pc = lut[lut_idx].
  - otherwise pc = pc+1, wrapping modulo 2^PC_W (max -> 0, no error).
- start is ignored in RUN.
- HALTED: done=1 and pc held. start=1 -> next edge: pc=start_addr, state=RUN, pc_valid=1, done=0.
- running is asserted only in RUN.
- flag is consumed as-is in the cycle branch_en is high; the ALU registers it, so no extra delay is inserted here.
- LUT writes: take effect on the edge when lut_we=1 and state is IDLE or HALTED. Writes in RUN are dropped.
- LUT reads are combinational from the register array. lut_idx is used only when taken.
- Latency: redirect (branch/start) reaches pc one edge after sampling. No delay slot, no bubble inserted by this block.
- Reset mid-RUN: immediate return to reset values. The LUT is cleared and must be reloaded.

Decomposition:
- Shared package core_pkg: fetch state enum (IDLE/RUN/HALTED), PC_W and LUT_AW constants, branch_sel encodings BNO=0/BOF=1 (matching ALU func codes).
- One sub-module, branch_lut: register array with write port gated by an external enable, async-reset clear, and combinational read.
- fetch_unit instantiates branch_lut and gates its write enable with (state != RUN).

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> pc=0, pc_valid=0, done=0 immediately. With no start for 5 cycles, pc stays 0.
- Sequential fetch: start=1, start_addr=0x010 -> pc = 0x010, 0x011, 0x012, 0x013 on successive edges; running=1.
- Branch taken/not taken: load lut[3]=0x200 in IDLE, start at 0x020. branch_en=1, lut_idx=3, branch_sel=1, flag=1 -> pc=0x200. Repeat with flag=0 -> pc=0x021.
- Stall priority: RUN at pc=0x040, stall=1 with halt_req=1 for 2 cycles -> pc stays 0x040, state RUN. Drop stall -> HALTED, done=1, pc=0x040.
- Wrap and restart: start_addr=0x3FE, 2 edges -> pc 0x3FF then 0x000. halt_req -> done=1. start with start_addr=0x005 -> pc=0x005, done=0.
- LUT write lockout: in RUN write lut[1]=0x111 -> later taken branch via idx 1 gives the old value. Same write in HALTED -> subsequent branch gives 0x111.
